output_compare_gen: RTL

Output-compare generator: the transmit-side counterpart of the input-capture unit in the timer I/O subsystem. The host queues 16-bit compare values into a small FIFO. When the selected timer value equals the armed compare value, the block drives the `outs` pin (toggle/set/clear) and pops the next value. Its output is used to synthesize edge streams that the capture block timestamps and checks for periodicity.

---
 rtl/io_timer_pkg.sv | 25 ++
 rtl/oc_fifo.sv | 52 +++++
 rtl/output_compare_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/io_timer_pkg.sv
// Shared definitions for the timer I/O subsystem (output-compare and input-capture).
// The optional periodic-reload feature of the compare block is enabled by OC_AUTO_RELOAD_EN.
package io_timer_pkg;

    localparam int TMR_W = 16;

    typedef enum logic [1:0] {
        OC_DIS = 2'b00,
        OC_TGL = 2'b01,
        OC_SET = 2'b10,
        OC_CLR = 2'b11
    } oc_mode_e;

    typedef enum logic {
        OC_IDLE  = 1'b0,
        OC_ARMED = 1'b1
    } oc_state_e;

    // Next compare at the same spacing as the previous pair, modulo 2^16.
    function automatic logic [TMR_W-1:0] oc_reload(input logic [TMR_W-1:0] cmp,
                                                   input logic [TMR_W-1:0] last);
        return cmp + (cmp - last);
    endfunction

endpackage

// File: rtl/oc_fifo.sv
// Compare-value queue: synchronous FIFO, power-of-two depth, registered full flag.
module oc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr + 1'b1) & MASK;
            if (pop)  rd_ptr <= (rd_ptr + 1'b1) & MASK;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/output_compare_gen.sv
// Output-compare generator: drives outs when the selected timer equals the armed compare value.
// Define OC_AUTO_RELOAD_EN to extrapolate the next compare when the queue runs dry.
module output_compare_gen
    import io_timer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       OCTMR,
    input  logic [1:0]       OCMODE,
    input  logic [TMR_W-1:0] t_val_bi_0,
    input  logic [TMR_W-1:0] t_val_bi_1,
    input  logic             wr_i,
    input  logic [TMR_W-1:0] OCBUF_i,
    output logic             outs,
    output logic             OCEV,
    output logic             OCBNF,
    output logic             OCOV,
    output logic             OCUR
);
    oc_state_e        state;
    oc_mode_e         mode;
    logic [TMR_W-1:0] cmp, last_cmp, t_sel, head;
    logic             match, pop, push, empty, full;
    logic [TMR_W:0]   unused_bits;

    assign mode  = oc_mode_e'(OCMODE);
    assign t_sel = OCTMR[0] ? t_val_bi_1 : t_val_bi_0;
    assign match = (state == OC_ARMED) && (t_sel == cmp);
    // Head leaves the queue on arming from IDLE or on reload after a match.
    assign pop   = (mode != OC_DIS) && !empty && ((state == OC_IDLE) || match);
    assign push  = wr_i && (!full || pop);
    assign OCBNF = !full;
    assign unused_bits = {OCTMR[1], last_cmp};

    oc_fifo #(.DEPTH(FIFO_DEPTH), .W(TMR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (OCBUF_i),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OC_IDLE;
            cmp      <= '0;
            last_cmp <= '0;
            outs     <= 1'b0;
            OCEV     <= 1'b0;
            OCOV     <= 1'b0;
            OCUR     <= 1'b0;
        end else begin
            OCEV <= 1'b0;
            if (wr_i && !push) OCOV <= 1'b1;
            if (mode == OC_DIS) begin
                state <= OC_IDLE;
            end else if (state == OC_IDLE) begin
                if (!empty) begin
                    cmp   <= head;
                    state <= OC_ARMED;
                end
            end else if (match) begin
                OCEV     <= 1'b1;
                last_cmp <= cmp;
                case (mode)
                    OC_TGL:  outs <= ~outs;
                    OC_SET:  outs <= 1'b1;
                    OC_CLR:  outs <= 1'b0;
                    default: outs <= outs;
                endcase
                if (!empty) begin
                    cmp <= head;
                end else begin
`ifdef OC_AUTO_RELOAD_EN
                    cmp <= oc_reload(cmp, last_cmp);
`else
                    state <= OC_IDLE;
                    OCUR  <= 1'b1;
`endif
                end
            end
        end
    end

endmodule
